pwm_gen_multi: RTL and testbench



---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_gen_multi_if.sv | 35 +++
 rtl/pwm_channel.sv | 75 +++++++
 rtl/pwm_gen_multi.sv | 86 ++++++++
 tb/tb_pwm_gen_multi.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings and reset constants for the pwm_gen_multi block.
//   pwm_mode_e : per-channel compare mode
//   MODE_RST / POL_RST : channel config values after reset
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_LEFT      = 2'b00,  // active while count <  cmp1
    PWM_RIGHT     = 2'b01,  // active while count >= cmp1
    PWM_UNALIGNED = 2'b10,  // active while cmp1 <= count < cmp2
    PWM_OFF       = 2'b11   // never active
  } pwm_mode_e;

  localparam pwm_mode_e MODE_RST = PWM_OFF;
  localparam logic      POL_RST  = 1'b0;

endpackage

// File: rtl/pwm_gen_multi_if.sv
// pwm_gen_multi_if: control/status bundle of the PWM generator.
//   slave  : view of the PWM block (takes enables and writes, drives counter/outputs)
//   master : view of the register file driving the block
interface pwm_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              pwm_en;
  logic              center_mode;
  logic              period_wr;
  logic [CNT_W-1:0]  period_in;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic              cfg_pol;
  logic [CNT_W-1:0]  cfg_cmp1;
  logic [CNT_W-1:0]  cfg_cmp2;
  logic [CNT_W-1:0]  count_val;
  logic              period_tick;
  logic [NUM_CH-1:0] pwm_out;

  modport slave (
    input  pwm_en, center_mode, period_wr, period_in,
           cfg_wr, cfg_ch, cfg_mode, cfg_pol, cfg_cmp1, cfg_cmp2,
    output count_val, period_tick, pwm_out
  );

  modport master (
    output pwm_en, center_mode, period_wr, period_in,
           cfg_wr, cfg_ch, cfg_mode, cfg_pol, cfg_cmp1, cfg_cmp2,
    input  count_val, period_tick, pwm_out
  );
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one compare channel of pwm_gen_multi.
//   i_wr            : write pending config (mode/pol/cmp1/cmp2)
//   i_load          : copy pending -> active this cycle (boundary or disabled)
//   i_en            : global enable; when low the output sits at its inactive level
//   i_cnt           : shared counter value
//   o_pwm           : registered PWM output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [1:0]       i_mode,
  input  logic             i_pol,
  input  logic [CNT_W-1:0] i_cmp1,
  input  logic [CNT_W-1:0] i_cmp2,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  pwm_mode_e        r_mode_p, r_mode_a;
  logic             r_pol_p,  r_pol_a;
  logic [CNT_W-1:0] r_cmp1_p, r_cmp1_a;
  logic [CNT_W-1:0] r_cmp2_p, r_cmp2_a;
  logic             r_pwm;

  // On a load cycle the config being copied is already the one in force, so
  // the boundary count (0) is evaluated with the new settings: no partial pulse.
  pwm_mode_e        w_mode;
  logic             w_pol;
  logic [CNT_W-1:0] w_cmp1, w_cmp2;
  logic             w_act;

  assign w_mode = i_load ? r_mode_p : r_mode_a;
  assign w_pol  = i_load ? r_pol_p  : r_pol_a;
  assign w_cmp1 = i_load ? r_cmp1_p : r_cmp1_a;
  assign w_cmp2 = i_load ? r_cmp2_p : r_cmp2_a;

  always_comb begin
    w_act = 1'b0;
    case (w_mode)
      PWM_LEFT:      w_act = (i_cnt <  w_cmp1);
      PWM_RIGHT:     w_act = (i_cnt >= w_cmp1);
      PWM_UNALIGNED: w_act = (i_cnt >= w_cmp1) && (i_cnt < w_cmp2);
      default:       w_act = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_p <= MODE_RST; r_pol_p <= POL_RST; r_cmp1_p <= '0; r_cmp2_p <= '0;
      r_mode_a <= MODE_RST; r_pol_a <= POL_RST; r_cmp1_a <= '0; r_cmp2_a <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr) begin
        r_mode_p <= pwm_mode_e'(i_mode);
        r_pol_p  <= i_pol;
        r_cmp1_p <= i_cmp1;
        r_cmp2_p <= i_cmp2;
      end
      r_mode_a <= w_mode;
      r_pol_a  <= w_pol;
      r_cmp1_a <= w_cmp1;
      r_cmp2_a <= w_cmp2;
      r_pwm    <= i_en ? (w_act ^ w_pol) : w_pol;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel PWM generator with a shared period counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : pwm_gen_multi_if.slave (enable, mode, shadowed period/channel
//                writes in; count_val, period_tick, pwm_out out)
// Period and channel configs are double-buffered and copied at each period
// boundary (count 0 while enabled) or every cycle while disabled.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_gen_multi_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  r_cnt, r_per_pend, r_per_act;
  logic              r_dir_dn, r_center_act;
  logic [CNT_W-1:0]  w_cnt_nxt, w_per;
  logic              w_dir_nxt, w_zero, w_load, w_ctr;
  logic [NUM_CH-1:0] w_pwm;

  assign w_zero = (r_cnt == '0);
  assign w_load = ~bus.pwm_en | w_zero;
  // Values in force for this count; on a load cycle they are the pending ones.
  assign w_per  = w_load ? r_per_pend : r_per_act;
  assign w_ctr  = w_load ? bus.center_mode : r_center_act;

  always_comb begin
    w_cnt_nxt = '0;
    w_dir_nxt = 1'b0;
    if (bus.pwm_en) begin
      if (w_zero) begin
        w_cnt_nxt = (w_per == '0) ? '0 : CNT_W'(1);
      end else if (!w_ctr) begin
        w_cnt_nxt = (r_cnt >= w_per) ? '0 : r_cnt + CNT_W'(1);
      end else if (r_dir_dn || (r_cnt >= w_per)) begin
        // r_cnt is nonzero here, so the decrement cannot underflow
        w_cnt_nxt = r_cnt - CNT_W'(1);
        w_dir_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dir_dn     <= 1'b0;
      r_per_pend   <= '0;
      r_per_act    <= '0;
      r_center_act <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_dir_dn     <= w_dir_nxt;
      r_per_act    <= w_per;
      r_center_act <= w_ctr;
      if (bus.period_wr) r_per_pend <= bus.period_in;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (bus.cfg_wr && (bus.cfg_ch == CH_W'(g))),
      .i_mode (bus.cfg_mode),
      .i_pol  (bus.cfg_pol),
      .i_cmp1 (bus.cfg_cmp1),
      .i_cmp2 (bus.cfg_cmp2),
      .i_load (w_load),
      .i_en   (bus.pwm_en),
      .i_cnt  (r_cnt),
      .o_pwm  (w_pwm[g])
    );
  end

  assign bus.count_val   = r_cnt;
  assign bus.period_tick = bus.pwm_en & w_zero;
  assign bus.pwm_out     = w_pwm;

endmodule

// File: tb/tb_pwm_gen_multi.sv
module tb_pwm_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  pwm_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A period is a sequence of phases k = 0..len-1; the count is k on the way
  // up and mirrors back down in center mode. Config in force for a period is
  // whatever was pending when its phase 0 started.
  typedef struct { int mode; int pol; int c1; int c2; } cfg_t;
  cfg_t m_pend[NUM_CH], m_act[NUM_CH];
  int   m_pp, m_pa, m_k;
  bit   m_ca;
  bit [NUM_CH-1:0] m_out;

  function automatic int f_cnt(int k);
    return (m_ca && k > m_pa) ? 2 * m_pa - k : k;
  endfunction
  function automatic int f_len();
    if (m_pa == 0) return 1;
    return m_ca ? 2 * m_pa : m_pa + 1;
  endfunction
  function automatic bit f_lvl(cfg_t c, int v);
    case (c.mode)
      0: return v < c.c1;
      1: return v >= c.c1;
      2: return (c.c1 <= v) && (v < c.c2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_k = 0; m_pp = 0; m_pa = 0; m_ca = 0; m_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = '{3, 0, 0, 0};
      m_act[i]  = '{3, 0, 0, 0};
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        if (!bus.pwm_en || m_k == 0) begin
          m_act = m_pend; m_pa = m_pp; m_ca = bus.center_mode;
        end
        if (!bus.pwm_en) begin
          for (int i = 0; i < NUM_CH; i++) m_out[i] = m_act[i].pol[0];
          m_k = 0;
        end else begin
          for (int i = 0; i < NUM_CH; i++)
            m_out[i] = f_lvl(m_act[i], f_cnt(m_k)) ^ m_act[i].pol[0];
          m_k++;
          if (m_k >= f_len()) m_k = 0;
        end
        if (bus.period_wr) m_pp = int'(bus.period_in);
        if (bus.cfg_wr && int'(bus.cfg_ch) < NUM_CH)
          m_pend[bus.cfg_ch] = '{int'(bus.cfg_mode), int'(bus.cfg_pol),
                                 int'(bus.cfg_cmp1), int'(bus.cfg_cmp2)};
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("count_val",   bus.count_val,   f_cnt(m_k));
    chk("period_tick", bus.period_tick, (bus.pwm_en && m_k == 0) ? 1 : 0);
    chk("pwm_out",     bus.pwm_out,     m_out);
  end

  // ---------------- stimulus ----------------
  int w_t;
  int w_hi[NUM_CH];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wr_per(input int p);
    bus.period_in = CNT_W'(p); bus.period_wr = 1'b1; tick(); bus.period_wr = 1'b0;
  endtask

  task automatic wr_cfg(input int ch, input int mode, input int pol, input int c1, input int c2);
    bus.cfg_ch = 2'(ch); bus.cfg_mode = 2'(mode); bus.cfg_pol = pol[0];
    bus.cfg_cmp1 = CNT_W'(c1); bus.cfg_cmp2 = CNT_W'(c2); bus.cfg_wr = 1'b1;
    tick(); bus.cfg_wr = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int n = 0;
    while (m_k != k && n < 200) begin tick(); n++; end
    if (m_k != k) begin
      n_chk++; n_fail++;
      $display("FAIL wait_k timeout: phase %0d expected %0d", m_k, k);
    end
  endtask

  task automatic window(input int n);
    w_t = 0;
    for (int i = 0; i < NUM_CH; i++) w_hi[i] = 0;
    repeat (n) begin
      @(negedge clk);
      w_t += int'(bus.period_tick);
      for (int i = 0; i < NUM_CH; i++) w_hi[i] += int'(bus.pwm_out[i]);
    end
    tick();
  endtask

  initial begin
    bus.pwm_en = 0; bus.center_mode = 0; bus.period_wr = 0; bus.period_in = '0;
    bus.cfg_wr = 0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_pol = 0;
    bus.cfg_cmp1 = '0; bus.cfg_cmp2 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic up-count channels, P=9
    wr_per(9);
    wr_cfg(0, 0, 0, 3, 0);
    wr_cfg(1, 1, 0, 7, 0);
    wr_cfg(2, 2, 0, 2, 6);
    bus.pwm_en = 1'b1;
    repeat (5) tick();
    window(20);
    chk("up_ticks", w_t, 2);
    chk("up_ch0_left", w_hi[0], 6);
    chk("up_ch1_right", w_hi[1], 6);
    chk("up_ch2_unaligned", w_hi[2], 8);
    chk("up_ch3_off", w_hi[3], 0);

    // Mid-period write lands at next boundary; boundary-cycle write one period later
    wait_k(4);
    wr_cfg(0, 0, 0, 5, 0);
    wait_k(0);
    wr_cfg(0, 0, 0, 7, 0);
    window(10);
    chk("shadow_first", w_hi[0], 5);
    window(10);
    chk("shadow_boundary", w_hi[0], 7);

    // Center mode, P=8: 16-cycle period
    bus.center_mode = 1'b1;
    wr_per(8);
    repeat (40) tick();
    window(32);
    chk("center_ticks", w_t, 2);
    bus.center_mode = 1'b0;
    wr_per(9);

    // Edge cases
    wr_cfg(0, 0, 0, 0, 0);
    wr_cfg(1, 0, 0, 12, 0);
    wr_cfg(2, 2, 0, 6, 6);
    wr_cfg(3, 0, 1, 3, 0);
    repeat (25) tick();
    window(20);
    chk("edge_cmp0_low", w_hi[0], 0);
    chk("edge_cmp_gt_p_high", w_hi[1], 20);
    chk("edge_eq_cmp_low", w_hi[2], 0);
    chk("edge_pol_inv", w_hi[3], 14);

    // P=0: tick every cycle
    wr_per(0);
    repeat (15) tick();
    window(10);
    chk("p0_ticks", w_t, 10);
    chk("p0_ch1_high", w_hi[1], 10);

    // Enable drop, re-enable, async reset
    wr_per(9);
    repeat (25) tick();
    wait_k(5);
    bus.pwm_en = 1'b0;
    tick();
    chk("dis_count", bus.count_val, 0);
    chk("dis_pwm_pol", bus.pwm_out, 4'b1000);
    repeat (3) tick();
    bus.pwm_en = 1'b1;
    #1 chk("reen_tick", bus.period_tick, 1);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", bus.count_val, 0);
    chk("rst_pwm", bus.pwm_out, 0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.period_wr = ($urandom_range(0, 7) == 0);
      bus.period_in = CNT_W'($urandom_range(0, 20));
      bus.cfg_wr    = ($urandom_range(0, 3) == 0);
      bus.cfg_ch    = 2'($urandom_range(0, NUM_CH - 1));
      bus.cfg_mode  = 2'($urandom_range(0, 3));
      bus.cfg_pol   = 1'($urandom_range(0, 1));
      bus.cfg_cmp1  = CNT_W'($urandom_range(0, 24));
      bus.cfg_cmp2  = CNT_W'($urandom_range(0, 24));
      if ($urandom_range(0, 63) == 0) bus.center_mode = ~bus.center_mode;
      if ($urandom_range(0, 99) == 0) bus.pwm_en = ~bus.pwm_en;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    bus.period_wr = 0; bus.cfg_wr = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
